// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one transaction at a time on a
// valid/grant/rvalid data port and stalls the pipeline until it completes.
module lsu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                is_fault;
    logic [3:0]          be_new;
    logic [DATA_W-1:0]   wdata_new;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   load_ext;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    // Acceptance-time decode: legality/alignment and store lane placement.
    always_comb begin
        case (funct3_i)
            3'b000:  is_fault = 1'b0;
            3'b001:  is_fault = addr_i[0];
            3'b010:  is_fault = |addr_i[1:0];
            3'b100:  is_fault = mem_write_i;
            3'b101:  is_fault = mem_write_i | addr_i[0];
            default: is_fault = 1'b1;
        endcase

        be_new    = 4'b1111;
        wdata_new = '0;
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << addr_i[1:0];
                    wdata_new = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << addr_i[1:0];
                    wdata_new = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata_i;
                end
            endcase
        end
    end

    always_comb begin
        lane = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_i) state_d = is_fault ? DONE : REQ;
            REQ:  if (dmem_gnt_i) state_d = (we_q || dmem_rvalid_i) ? DONE : WAIT;
            WAIT: if (dmem_rvalid_i) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Operation context is captured once at acceptance and held until DONE.
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d     = mem_write_i;
                    funct3_d = funct3_i;
                    off_d    = addr_i[1:0];
                    addr_d   = {addr_i[ADDR_W-1:2], 2'b00};
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    fault_d  = is_fault;
                    rdata_d  = '0;
                end
            end
            REQ:  if (dmem_gnt_i && !we_q && dmem_rvalid_i) rdata_d = load_ext;
            WAIT: if (dmem_rvalid_i) rdata_d = load_ext;
            default: ;
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        done_o       = 1'b0;
        fault_o      = 1'b0;
        rdata_o      = '0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        case (state_q)
            IDLE: busy_o = req_valid_i;
            REQ: begin
                busy_o       = 1'b1;
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = addr_q;
                dmem_be_o    = be_q;
                dmem_wdata_o = wdata_q;
            end
            WAIT: busy_o = 1'b1;
            default: begin
                done_o  = 1'b1;
                fault_o = fault_q;
                rdata_o = rdata_q;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a byte-level reference memory predicts
// each op's result; a memory responder and a completion monitor check the DUT.
module tb_lsu_mem_stage;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic [31:0] busy;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  gd;
        logic [7:0]  rd;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] slave_mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          outstanding = 0;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .mem_write_i  (mem_write),
        .funct3_i     (funct3),
        .addr_i       (addr_in),
        .wdata_i      (wdata_in),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fault_o      (fault_o),
        .rdata_o      (rdata_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preloadWord(input logic [31:0] addr, input logic [31:0] word);
        slave_mem[addr[11:2]] = word;
        for (int i = 0; i < 4; i++) ref_mem[int'({addr[11:2], 2'b00}) + i] = word[8*i +: 8];
    endtask

    // Reference model: predicts result, busy length and memory request from byte-level rules.
    task automatic modelAndDrive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int gd, input int rd);
        int          size   = int'(f3[1:0]);
        int          nbytes = 1 << size;
        int          off    = int'(addr[1:0]);
        int          base   = int'(addr[11:0]);
        logic        uns    = f3[2];
        logic        bad    = (size == 3) || (uns && (we || size == 2)) || ((off % nbytes) != 0);
        exp_t        e;
        req_t        r;
        logic [31:0] val = 32'h0;
        e.fault = bad;
        e.rdata = 32'h0;
        e.busy  = 32'd1;
        if (!bad) begin
            r.we    = we;
            r.addr  = {addr[31:2], 2'b00};
            r.gd    = 8'(gd);
            r.rd    = 8'(rd);
            r.be    = 4'b0000;
            r.wdata = 32'h0;
            if (we) begin
                for (int i = 0; i < nbytes; i++) begin
                    r.be[off + i] = 1'b1;
                    ref_mem[base + i] = wd[8*i +: 8];
                end
                for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wd[8*(k % nbytes) +: 8];
                e.busy = 32'(2 + gd);
            end else begin
                r.be = 4'b1111;
                for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[base + i];
                if (!uns && nbytes < 4 && val[8*nbytes-1])
                    for (int i = 8*nbytes; i < 32; i++) val[i] = 1'b1;
                e.rdata = val;
                e.busy  = 32'(2 + gd + rd);
            end
            req_q.push_back(r);
        end
        exp_q.push_back(e);
        mem_write = we;
        funct3    = f3;
        addr_in   = addr;
        wdata_in  = wd;
        req_valid = 1'b1;
        outstanding++;
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(posedge clk); #1;
        while (outstanding != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (outstanding != 0) begin
            checkOutput("completion_timeout", outstanding, 0);
            exp_q.delete();
            req_q.delete();
            outstanding = 0;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int gd, input int rd);
        waitIdle();
        modelAndDrive(we, f3, addr, wd, gd, rd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_write = 1'($urandom);
        funct3    = 3'($urandom);
        addr_in   = $urandom;
        wdata_in  = $urandom;
    endtask

    task automatic backToBack();
        int guard = 0;
        waitIdle();
        modelAndDrive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0);
        @(posedge clk); #1;
        modelAndDrive(1'b0, 3'b010, 32'h10, 32'h0, 0, 1);
        while (outstanding == 2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_dmem_req", dmem_req_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_fault", fault_o, 0);
        checkOutput("rst_rdata", rdata_o, 0);
        checkOutput("rst_dmem_be", dmem_be_o, 0);
        exp_q.delete();
        req_q.delete();
        outstanding = 0;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Memory responder: applies per-op grant/rvalid delays and checks the request port.
    initial begin
        int   wait_cnt;
        int   rv_cnt;
        int   rd_idx;
        logic pending;
        req_t cur;
        wait_cnt    = 0;
        rv_cnt      = 0;
        rd_idx      = 0;
        pending     = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        forever begin
            @(posedge clk); #1;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (!rst_n) begin
                wait_cnt = 0;
                pending  = 1'b0;
            end else if (pending) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = slave_mem[rd_idx];
                    pending     = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (dmem_req_o) begin
                if (req_q.size() == 0) begin
                    checkOutput("unexpected_req", dmem_req_o, 0);
                end else begin
                    cur = req_q[0];
                    checkOutput("dmem_we", dmem_we_o, cur.we);
                    checkOutput("dmem_addr", dmem_addr_o, cur.addr);
                    checkOutput("dmem_be", dmem_be_o, cur.be);
                    if (cur.we) begin
                        checkOutput("dmem_wdata", dmem_wdata_o, cur.wdata);
                        dmem_rvalid = 1'($urandom_range(0, 1));
                    end
                    if (wait_cnt == int'(cur.gd)) begin
                        dmem_gnt = 1'b1;
                        wait_cnt = 0;
                        void'(req_q.pop_front());
                        if (cur.we) begin
                            for (int k = 0; k < 4; k++)
                                if (dmem_be_o[k]) slave_mem[dmem_addr_o[11:2]][8*k +: 8] = dmem_wdata_o[8*k +: 8];
                        end else if (cur.rd == 8'd0) begin
                            dmem_rvalid = 1'b1;
                            dmem_rdata  = slave_mem[dmem_addr_o[11:2]];
                        end else begin
                            pending = 1'b1;
                            rv_cnt  = int'(cur.rd) - 1;
                            rd_idx  = int'(dmem_addr_o[11:2]);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));
                checkOutput("idle_dmem_we", dmem_we_o, 0);
                checkOutput("idle_dmem_be", dmem_be_o, 0);
                checkOutput("idle_dmem_wdata", dmem_wdata_o, 0);
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                continue;
            end
            if (fault_o && !done_o) checkOutput("fault_without_done", fault_o, 0);
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", done_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("fault", fault_o, e.fault);
                    checkOutput("rdata", rdata_o, e.rdata);
                    checkOutput("busy_cycles", busy_cnt, e.busy);
                    checkOutput("busy_in_done", busy_o, 0);
                    outstanding--;
                end
                busy_cnt = 0;
            end else if (busy_o) begin
                busy_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr_in   = 32'h0;
        wdata_in  = 32'h0;
        for (int w = 0; w < 1024; w++) preloadWord(32'(w * 4), $urandom);
        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_fault", fault_o, 0);
        checkOutput("reset_rdata", rdata_o, 0);
        checkOutput("reset_dmem_req", dmem_req_o, 0);
        checkOutput("reset_dmem_addr", dmem_addr_o, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        preloadWord(32'h100, 32'h80AB_CDEF);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 2);
        preloadWord(32'h200, 32'h8001_1234);
        applyStimulus(1'b0, 3'b101, 32'h202, 32'h0, 0, 0);
        applyStimulus(1'b1, 3'b000, 32'h301, 32'h1234_56A5, 3, 0);
        applyStimulus(1'b0, 3'b010, 32'h402, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'b011, 32'h400, 32'h0, 0, 0);
        applyStimulus(1'b1, 3'b101, 32'h404, 32'h5555_AAAA, 0, 0);
        backToBack();

        preloadWord(32'h20, 32'h0BAD_F00D);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0, 20);
        @(posedge clk); #1;
        checkOutput("inflight_busy", busy_o, 1);
        resetPulse();
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1, 1);

        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 20, 0);
        checkOutput("req_before_reset", dmem_req_o, 1);
        resetPulse();
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                default: f3 = 3'($urandom);
            endcase
            addr = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            applyStimulus(we, f3, addr, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        waitIdle();
        repeat (5) @(posedge clk);
        checkOutput("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
